// File: rtl/fifo_pop_stage.sv
// Pops a std-read-mode FIFO into an in-order skid buffer and presents valid/ready beats; 2-cycle first beat, 1 beat/cycle.
// Backpressure fills the skid to SKID_DEPTH, then pops stop; flush drops buffered and returning data.
module fifo_pop_stage #(
    parameter int  DATA_WIDTH = 32,
    parameter int  SKID_DEPTH = 2,
    localparam int CNT_WIDTH  = $clog2(SKID_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  a_rst,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_pop_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic [CNT_WIDTH-1:0]  occ_o
);

    localparam int                PTR_W     = $clog2(SKID_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(SKID_DEPTH - 1);
    localparam logic [CNT_WIDTH:0] DEPTH_EXT = (CNT_WIDTH + 1)'(SKID_DEPTH);

    generate
        if (SKID_DEPTH < 2) begin : g_depth_chk
            $error("fifo_pop_stage: SKID_DEPTH must be >= 2");
        end
    endgenerate

    logic                  inflight;
    logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_WIDTH-1:0]  occ;
    logic                  deq;
    logic                  capture;
    logic [CNT_WIDTH:0]    committed;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (occ != '0);
    assign data_o  = skid_mem[rd_ptr];
    assign occ_o   = occ;
    assign deq     = valid_o & ready_i;
    assign capture = inflight & ~flush_i;

    // Slots already claimed once this cycle's dequeue leaves: buffered plus the word still in flight.
    assign committed = {1'b0, occ} + {{CNT_WIDTH{1'b0}}, inflight} - {{CNT_WIDTH{1'b0}}, deq};

    assign fifo_pop_o = ~a_rst & ~flush_i & ~fifo_empty_i & (committed < DEPTH_EXT);

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            inflight <= 1'b0;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (flush_i) begin
            inflight <= 1'b0;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= fifo_pop_o;
            if (capture) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({capture, deq})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            skid_mem[wr_ptr] <= fifo_data_i;
        end
    end

`ifdef DEBUG
    always_ff @(posedge clk) begin
        if (!a_rst && capture) begin
            assert ({1'b0, occ} < DEPTH_EXT);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_pop_stage.sv
// Randomized bench for fifo_pop_stage: a queue-based FIFO feeds the DUT, a scoreboard tracks popped words.
// Each tracked word becomes visible two cycles after its pop; flush or reset discards everything tracked.
module tb_fifo_pop_stage;

    localparam int DW = 32;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          a_rst = 1'b0;
    logic          flush_i = 1'b0;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_pop_o;
    logic [DW-1:0] fifo_data_i = '0;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          ready_i = 1'b0;
    logic [CW-1:0] occ_o;

    fifo_pop_stage #(.DATA_WIDTH(DW), .SKID_DEPTH(D)) dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_pop_o   (fifo_pop_o),
        .fifo_data_i  (fifo_data_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .ready_i      (ready_i),
        .occ_o        (occ_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dat;
        int            pc;
    } ent_t;

    ent_t          exp_q[$];
    logic [DW-1:0] src_q[$];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] nxt_dat = '0;
    logic          have_nxt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus: drive just after the rising edge, record any pop at the falling edge.
    task automatic tick(input logic rst, input logic rdy, input logic hide, input logic fl);
        @(posedge clk);
        #1;
        a_rst        = rst;
        ready_i      = rdy;
        flush_i      = fl;
        fifo_data_i  = have_nxt ? nxt_dat : DW'($urandom);
        fifo_empty_i = hide || (src_q.size() == 0);
        @(negedge clk);
        have_nxt = 1'b0;
        if (a_rst) begin
            exp_q.delete();
        end else if (fifo_pop_o && src_q.size() != 0) begin
            nxt_dat = src_q.pop_front();
            exp_q.push_back('{nxt_dat, cyc});
            have_nxt = 1'b1;
        end
    endtask

    // Monitor: a word popped in cycle N is presented from cycle N+2 on, in pop order.
    always @(negedge clk) begin
        int   n_old;
        int   n_rdy;
        logic exp_v;
        logic exp_deq;
        logic exp_pop;
        n_old = 0;
        n_rdy = 0;
        if (a_rst) begin
            chk("rst_pop", DW'(fifo_pop_o), '0);
            chk("rst_valid", DW'(valid_o), '0);
            chk("rst_occ", DW'(occ_o), '0);
        end else begin
            foreach (exp_q[i]) begin
                if (exp_q[i].pc < cyc)     n_old++;
                if (exp_q[i].pc <= cyc - 2) n_rdy++;
            end
            exp_v   = (n_rdy != 0);
            exp_deq = exp_v && ready_i;
            exp_pop = !fifo_empty_i && !flush_i && ((n_old - int'(exp_deq)) < D);
            chk("valid", DW'(valid_o), DW'(exp_v));
            chk("occ", DW'(occ_o), DW'(n_rdy));
            chk("pop", DW'(fifo_pop_o), DW'(exp_pop));
            if (exp_deq) begin
                chk("data", data_o, exp_q[0].dat);
                void'(exp_q.pop_front());
            end
            if (flush_i) exp_q.delete();
        end
    end

    initial begin
        a_rst = 1'b1;
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(32'h10 + i));

        // Reset with data waiting, then the first pop right after release.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("release_pop", DW'(fifo_pop_o), 32'd1);

        // Full-rate stream.
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Backpressure until the buffer is full, then drain.
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(32'h20 + i));
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_occ_full", DW'(occ_o), DW'(D));
        chk("bp_no_pop", DW'(fifo_pop_o), '0);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Flush with one word buffered and one in flight.
        for (int i = 0; i < 6; i++) src_q.push_back(DW'(32'h30 + i));
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_flush_valid", DW'(valid_o), '0);
        chk("post_flush_occ", DW'(occ_o), '0);
        chk("post_flush_pop", DW'(fifo_pop_o), 32'd1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Single entry: one pop, one beat, then idle on empty.
        src_q.push_back(32'hAB);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("empty_idle_pop", DW'(fifo_pop_o), '0);

        // Random traffic, flushes and occasional mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0 && src_q.size() < 8) src_q.push_back(DW'($urandom));
            tick(($urandom_range(0, 499) == 0),
                 logic'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 31) == 0));
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
